fix2float: RTL
==============

FIX2FLOAT -- requirements
Module: fix2float

Interface
REQ-001 Ports SHALL be: clk, input, 1, rising-edge clock; one clock domain only.
REQ-002 Ports SHALL include: reset_n, input, 1, asynchronous, active-low reset.
REQ-003 Ports SHALL include: clk_en, input, 1, clock enable; low freezes all state.
REQ-004 Ports SHALL include: start, input, 1, single-cycle conversion request.
REQ-005 Ports SHALL include: dataa, input, 32, signed two's-complement fixed-point operand with 30 fractional bits (value = dataa/2^30, range [-2,2)).
REQ-006 Ports SHALL include: done, output, 1, one-cycle completion pulse.
REQ-007 Ports SHALL include: result, output, 32, IEEE-754 single-precision equivalent of dataa.

Function
REQ-008 States SHALL be IDLE, ABS, NORM, PACK; IDLE is the only state accepting start.
REQ-009 In IDLE with start=1 and clk_en=1 (edge E0), dataa SHALL be captured and the sign taken from dataa[31].
REQ-010 If captured dataa=0, done SHALL assert at E1 with result=0x00000000, and the state SHALL return to IDLE.
REQ-011 If dataa is nonzero, the state SHALL go to ABS, which stores the 32-bit magnitude; 0x80000000 SHALL yield magnitude 0x80000000 (value 2.0).
REQ-012 In NORM, the block SHALL test mag[31] each cycle: if 0, shift mag left one bit and stay; if 1, go to PACK.
REQ-013 With p = index of the magnitude MSB, exponent SHALL be p+97 and mantissa SHALL be the 23 bits below the MSB.
REQ-014 PACK SHALL register result = {sign, exponent[7:0], mantissa}, assert done for exactly one cycle, and return to IDLE.
REQ-015 Latency: done SHALL assert at edge E(3+31-p) for nonzero inputs, giving a range of 3..34 cycles.
REQ-016 start asserted outside IDLE SHALL be ignored, with no queuing.
REQ-017 result SHALL hold its value from done until the next done.
REQ-018 done SHALL be 0 in every cycle except the completion cycle.
REQ-019 With clk_en=0, state, counters, result and done SHALL all hold; latency counts only enabled edges.
REQ-020 Denormals, infinities and NaN SHALL never be produced, because the exponent range is 97..128.

Reset
REQ-021 On reset_n=0, the state SHALL go to IDLE, done to 0, result to 0x00000000 and internal registers to 0, asynchronously.
REQ-022 A reset asserted mid-conversion SHALL abort it without a done pulse, and the first start after release SHALL be serviced normally.

Configuration
REQ-023 Macro FIX2FLOAT_ROUND_EN SHALL, when undefined, truncate the mantissa (round toward zero on the magnitude).
REQ-024 With FIX2FLOAT_ROUND_EN defined, PACK SHALL round to nearest-even using guard bit = normalized mag[7] and sticky = OR(mag[6:0]).
REQ-025 With FIX2FLOAT_ROUND_EN defined, a mantissa carry-out SHALL clear the mantissa and increment the exponent, within the same PACK cycle, with latency unchanged.

Verification
REQ-026 Unit values: dataa=0x40000000 -> result 0x3F800000, done at E4; dataa=0xC0000000 -> 0xBF800000, done at E4.
REQ-027 Extremes: dataa=0x00000001 -> 0x30800000, done at E34; dataa=0x80000000 -> 0xC0000000, done at E3; dataa=0x00000000 -> 0x00000000, done at E1.
REQ-028 Half and rounding: dataa=0x20000000 -> 0x3F000000; dataa=0x3FFFFFFF -> 0x3F7FFFFF without the macro, 0x3F800000 with FIX2FLOAT_ROUND_EN.
REQ-029 Busy and stall: a second start during NORM is ignored and yields one done only; clk_en held low 5 cycles mid-NORM delays done by exactly 5 cycles with an unchanged result.
REQ-030 Reset mid-operation: reset_n pulsed low during NORM -> done stays 0, result=0x00000000, and the next start with 0x40000000 -> 0x3F800000.

Source files
------------

// File: rtl/fix2float.sv
// Sequential Q2.30 fixed-point to IEEE-754 single-precision converter.
// Optional round-to-nearest-even mantissa rounding via `define FIX2FLOAT_ROUND_EN.
module fix2float (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAbs  = 2'd1,
        StNorm = 2'd2,
        StPack = 2'd3
    } state_e;

    state_e      state_q, state_d;

    logic [31:0] data_q;
    logic        sign_q;
    logic [31:0] mag_q;
    logic [4:0]  shift_q;
    logic [31:0] result_q;
    logic        done_q;

    // Control strobes decoded from the current state
    logic        capture;
    logic        load_mag;
    logic        shift_en;
    logic        finish_zero;
    logic        finish_pack;

    logic        data_zero;
    logic [7:0]  exp_raw;
    logic [22:0] mant_raw;
    logic [7:0]  exp_fin;
    logic [22:0] mant_fin;
    logic [31:0] packed_word;

    assign data_zero = (data_q == 32'd0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else if (clk_en) begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start)     state_d = StAbs;
            StAbs:  state_d = data_zero ? StIdle : StNorm;
            StNorm: if (mag_q[31]) state_d = StPack;
            StPack: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        capture     = 1'b0;
        load_mag    = 1'b0;
        shift_en    = 1'b0;
        finish_zero = 1'b0;
        finish_pack = 1'b0;
        unique case (state_q)
            StIdle: capture = start;
            StAbs: begin
                load_mag    = ~data_zero;
                finish_zero = data_zero;
            end
            StNorm: shift_en = ~mag_q[31];
            StPack: finish_pack = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Packing: MSB sits at bit 31 once normalised, so p = 31 - shift_q
    // and the biased exponent p + 97 becomes 128 - shift_q.
    // ------------------------------------------------------------------
    assign exp_raw  = 8'd128 - {3'b000, shift_q};
    assign mant_raw = mag_q[30:8];

`ifdef FIX2FLOAT_ROUND_EN
    logic        guard_bit;
    logic        sticky_bit;
    logic        round_up;
    logic [23:0] mant_sum;

    assign guard_bit  = mag_q[7];
    assign sticky_bit = |mag_q[6:0];
    assign round_up   = guard_bit & (sticky_bit | mag_q[8]);
    assign mant_sum   = {1'b0, mant_raw} + {23'd0, round_up};
    // A carry out leaves the low 23 bits at zero, so only the exponent moves
    assign mant_fin   = mant_sum[22:0];
    assign exp_fin    = exp_raw + {7'd0, mant_sum[23]};
`else
    logic unused_round_bits;

    assign unused_round_bits = ^mag_q[7:0];
    assign mant_fin          = mant_raw;
    assign exp_fin           = exp_raw;
`endif

    assign packed_word = {sign_q, exp_fin, mant_fin};

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= 32'd0;
            sign_q  <= 1'b0;
            mag_q   <= 32'd0;
            shift_q <= 5'd0;
        end else if (clk_en) begin
            if (capture) begin
                data_q  <= dataa;
                sign_q  <= dataa[31];
                shift_q <= 5'd0;
            end
            if (load_mag) begin
                // Negating 0x80000000 wraps back to itself, giving magnitude 2.0
                mag_q <= sign_q ? (~data_q + 32'd1) : data_q;
            end
            if (shift_en) begin
                mag_q   <= {mag_q[30:0], 1'b0};
                shift_q <= shift_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_q <= 32'd0;
            done_q   <= 1'b0;
        end else if (clk_en) begin
            done_q <= finish_zero | finish_pack;
            if (finish_zero) begin
                result_q <= 32'd0;
            end else if (finish_pack) begin
                result_q <= packed_word;
            end
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule
